// File: rtl/lcd_frame_capture_if.sv
// Parallel RGB565 LCD video bus: syncs, data enable and colour channels.
// The source drives the bus and the capture block receives it.
interface lcd_frame_capture_if;
  logic       vid_hsync;
  logic       vid_vsync;
  logic       vid_de;
  logic [4:0] vid_r;
  logic [5:0] vid_g;
  logic [4:0] vid_b;

  modport master (
    output vid_hsync, vid_vsync, vid_de, vid_r, vid_g, vid_b
  );

  modport slave (
    input vid_hsync, vid_vsync, vid_de, vid_r, vid_g, vid_b
  );
endinterface

// File: rtl/lcd_frame_capture.sv
// Captures a window of an incoming RGB565 LCD stream and decimates it by 4 in X and Y.
// Each kept pixel is written as RGB332 to a 64x64 video RAM. Line and frame sizes are measured.
module lcd_frame_capture #(
  parameter int unsigned START_X    = 160,
  parameter int unsigned START_Y    = 18,
  parameter int unsigned WIN_W      = 256,
  parameter int unsigned WIN_H      = 256,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_frame_capture_if.slave   vid,
  input  logic                 arm,
  output logic                 wr_en,
  output logic [11:0]          wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          line_pixels,
  output logic [15:0]          frame_lines
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE
  } state_t;

  state_t state, state_nxt;
  logic   done_nxt;

  logic       s1_hs, s1_vs, s1_de;
  logic [4:0] s1_r;
  logic [5:0] s1_g;
  logic [4:0] s1_b;
  logic       p_de, p_vs;

  logic [15:0] x, y, y_inc;
  logic        de_fall, vs_fall;
  logic        in_x, in_y, keep;
  logic [7:0]  xrel, yrel;

  logic unused_bits;
  assign unused_bits = ^{s1_hs, s1_r[1:0], s1_g[2:0], s1_b[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_de <= 1'b0;
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
      p_de  <= 1'b0;
      p_vs  <= 1'b0;
    end else begin
      s1_hs <= vid.vid_hsync;
      s1_vs <= vid.vid_vsync;
      s1_de <= vid.vid_de;
      s1_r  <= vid.vid_r;
      s1_g  <= vid.vid_g;
      s1_b  <= vid.vid_b;
      p_de  <= s1_de;
      p_vs  <= s1_vs;
    end
  end

  assign de_fall = p_de & ~s1_de;
  assign vs_fall = p_vs & ~s1_vs;
  assign y_inc   = (y == '1) ? y : y + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      line_pixels <= '0;
      frame_lines <= '0;
    end else begin
      if (de_fall) begin
        x           <= '0;
        line_pixels <= x;
      end else if (s1_de && (x != '1)) begin
        x <= x + 16'd1;
      end
      // A line ending on the frame-start cycle still counts toward the finished frame.
      if (vs_fall) begin
        y           <= '0;
        frame_lines <= de_fall ? y_inc : y;
      end else if (de_fall) begin
        y <= y_inc;
      end
    end
  end

  // Only the low 8 bits of the relative coordinates matter; the range check keeps them below 256.
  assign xrel = 8'(x) - 8'(START_X);
  assign yrel = 8'(y) - 8'(START_Y);
  assign in_x = (32'(x) >= START_X) && (32'(x) < START_X + WIN_W);
  assign in_y = (32'(y) >= START_Y) && (32'(y) < START_Y + WIN_H);
  assign keep = s1_de && in_x && in_y && (xrel[1:0] == 2'b00) && (yrel[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (arm || CONTINUOUS) state_nxt = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (vs_fall) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (vs_fall) begin
          done_nxt  = 1'b1;
          state_nxt = CONTINUOUS ? CAPTURE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // A pixel on the frame-start cycle still carries the old frame's y, so it is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= keep && (state == CAPTURE) && !vs_fall;
      wr_addr    <= {yrel[7:2], xrel[7:2]};
      wr_data    <= {s1_r[4:2], s1_g[5:3], s1_b[4:3]};
      frame_done <= done_nxt;
    end
  end

endmodule
